// File: rtl/signed_display_driver.sv
// signed_display_driver: binary (signed/unsigned) to DIGITS active-low
// seven-segment codes via a sequential double-dabble conversion.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros and place
// the minus sign just above the most significant digit).
module signed_display_driver #(
  parameter int DIGITS = 6,
  parameter int WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_en,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic [4*DIGITS-1:0]     bcd_q, bcd_d, bcd_adj;
  logic                    carry_q, carry_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7*DIGITS-1:0]     seg_q, seg_d, seg_calc;
  logic                    ovf_q, ovf_d, ovf_calc;
  logic                    done_q, done_d;
  logic [7:0]              ndig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h18;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: add 3 to each nibble >= 5 before shifting
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  // Final result: digit count, overflow decision and segment encoding
  always_comb begin
    ndig = 8'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ndig = 8'(i + 1);
    end
    ovf_calc = carry_q | (sign_q & (ndig > 8'(DIGITS - 1)));
    seg_calc = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_calc) begin
        seg_calc[7*i +: 7] = SEG_MINUS;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (8'(i) < ndig)                  seg_calc[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        else if (sign_q && 8'(i) == ndig)  seg_calc[7*i +: 7] = SEG_MINUS;
        else                               seg_calc[7*i +: 7] = SEG_BLANK;
`else
        if (sign_q && i == DIGITS - 1)     seg_calc[7*i +: 7] = SEG_MINUS;
        else                               seg_calc[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`endif
      end
    end
  end

  // FSM next-state and datapath updates
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = value[WIDTH-1] & signed_en;
          mag_d   = sign_d ? (~value + 1'b1) : value;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj[4*DIGITS-2:0], mag_q, 1'b0};
        carry_d = carry_q | bcd_adj[4*DIGITS-1];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        seg_d   = seg_calc;
        ovf_d   = ovf_calc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset blanks the display
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_signed_display_driver.sv
// Scoreboard bench: two instances (6 and 4 digits) share stimulus; a
// decimal-arithmetic model pushes expectations, monitors pop on done.
module tb_signed_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_en = 1'b0;
  logic [15:0] value = '0;
  logic        busy6, done6, ovf6, busy4, done4, ovf4;
  logic [41:0] seg6;
  logic [27:0] seg4;

  typedef struct { logic [41:0] seg; bit ovf; } exp_t;
  exp_t q6[$], q4[$];
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  signed_display_driver #(.DIGITS(6), .WIDTH(16)) u_dut6 (
    .clk(clk), .rst(rst), .start(start), .signed_en(signed_en), .value(value),
    .busy(busy6), .done(done6), .overflow(ovf6), .seg(seg6));

  signed_display_driver #(.DIGITS(4), .WIDTH(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .signed_en(signed_en), .value(value),
    .busy(busy4), .done(done4), .overflow(ovf4), .seg(seg4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h18;
    endcase
  endfunction

  // Reference: plain decimal arithmetic on the numeric value
  function automatic exp_t model(input logic [15:0] v, input bit se, input int nd);
    exp_t r;
    bit neg;
    int mag, t, nz, lim;
    int dig[6];
    neg = se && v[15];
    mag = neg ? 65536 - int'(v) : int'(v);
    t = mag;
    for (int i = 0; i < 6; i++) begin dig[i] = t % 10; t = t / 10; end
    nz = 1;
    for (int i = 0; i < nd; i++) if (dig[i] != 0) nz = i + 1;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    r.ovf = (mag >= lim) || (neg && nz > nd - 1);
    r.seg = '0;
    for (int i = 0; i < nd; i++) begin
      if (r.ovf) r.seg[7*i +: 7] = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
      else if (i < nz) r.seg[7*i +: 7] = code(dig[i]);
      else if (neg && i == nz) r.seg[7*i +: 7] = 7'h3F;
      else r.seg[7*i +: 7] = 7'h7F;
`else
      else if (neg && i == nd - 1) r.seg[7*i +: 7] = 7'h3F;
      else r.seg[7*i +: 7] = code(dig[i]);
`endif
    end
    return r;
  endfunction

  // Monitors: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done6) begin
      if (q6.size() == 0) check("done6_spurious", 64'(done6), 64'd0);
      else begin
        exp_t e;
        e = q6.pop_front();
        check("seg6", 64'(seg6), 64'(e.seg));
        check("ovf6", 64'(ovf6), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) check("done4_spurious", 64'(done4), 64'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("seg4", 64'({14'd0, seg4}), 64'(e.seg));
        check("ovf4", 64'(ovf4), 64'(e.ovf));
      end
    end
  end

  task automatic conv(input logic [15:0] v, input bit se, input bit inject);
    int n;
    q6.push_back(model(v, se, 6));
    q4.push_back(model(v, se, 4));
    start = 1'b1; value = v; signed_en = se;
    @(negedge clk);                // edge 0 has sampled start
    start = 1'b0;
    check("busy_rise", 64'(busy6), 64'd1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin value = 16'($urandom); signed_en = 1'($urandom); end
      if (inject && n == 4) begin start = 1'b1; value = 16'd99; signed_en = 1'b0; end
      if (inject && n == 5) start = 1'b0;
      if (done6) break;
    end
    check("done_latency", 64'(n), 64'd17);
    check("busy_fall", 64'({busy6, busy4}), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_seg6", 64'(seg6), 64'h3FF_FFFF_FFFF);
    check("rst_seg4", 64'(seg4), 64'hFFF_FFFF);
    check("rst_flags", 64'({busy6, done6, ovf6, busy4, done4, ovf4}), 64'd0);
    @(negedge clk);

    conv(16'd1234, 1'b0, 1'b0);
    conv(16'hFFF6, 1'b1, 1'b0);
    conv(16'h8000, 1'b1, 1'b0);
    conv(16'd12345, 1'b0, 1'b0);
    conv(16'd42, 1'b0, 1'b1);

    // Reset sampled at edge 8 aborts the conversion
    start = 1'b1; value = 16'd555; signed_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'({busy6, busy4}), 64'd0);
    check("abort_done", 64'({done6, done4}), 64'd0);
    check("abort_seg6", 64'(seg6), 64'h3FF_FFFF_FFFF);
    check("abort_seg4", 64'(seg4), 64'hFFF_FFFF);
    repeat (25) @(negedge clk);

    conv(16'd0, 1'b0, 1'b0);
    conv(16'hFFFF, 1'b0, 1'b0);
    conv(16'hFFFF, 1'b1, 1'b0);
    conv(16'h7FFF, 1'b1, 1'b0);
    conv(16'd9999, 1'b0, 1'b0);
    conv(16'd10000, 1'b0, 1'b0);
    conv(16'hFC19, 1'b1, 1'b0);   // -999
    conv(16'hFC18, 1'b1, 1'b0);   // -1000
    for (int k = 0; k < 30; k++) conv(16'($urandom), 1'($urandom), 1'b0);

    repeat (5) @(negedge clk);
    check("q6_drained", 64'(q6.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
